// File: rtl/solver_pkg.sv
// Shared definitions for the solver and its dispatcher: default limb widths
// and the dispatcher FSM encoding.
package solver_pkg;

  localparam int DEF_LIMB_INDEX_BITS = 6;
  localparam int DEF_LIMB_SIZE_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } disp_state_e;

endpackage

// File: rtl/solver_dispatch.sv
// Feeds one pixel job limb-serially into a solver, starts it and returns the result.
// Latency: first limb write one cycle after accept; res_valid one cycle after done; holds results until res_ready.
module solver_dispatch
  import solver_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = DEF_LIMB_INDEX_BITS,
  parameter int LIMB_SIZE_BITS  = DEF_LIMB_SIZE_BITS,
  parameter int NUM_LIMBS       = 4,
  parameter int TAG_BITS        = 16,
  parameter int CYCLE_BITS      = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                job_valid,
  output logic                                job_ready,
  input  logic [NUM_LIMBS*LIMB_SIZE_BITS-1:0] job_re,
  input  logic [NUM_LIMBS*LIMB_SIZE_BITS-1:0] job_im,
  input  logic [TAG_BITS-1:0]                 job_tag,
  output logic                                wr_en,
  output logic [LIMB_INDEX_BITS-1:0]          wr_limb,
  output logic [LIMB_SIZE_BITS-1:0]           wr_data_re,
  output logic [LIMB_SIZE_BITS-1:0]           wr_data_im,
  output logic                                start,
  input  logic                                solver_done,
  input  logic                                solver_output,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic                                res_diverged,
  output logic [CYCLE_BITS-1:0]               res_cycles,
  output logic [TAG_BITS-1:0]                 res_tag
);

  localparam int JOB_BITS = NUM_LIMBS * LIMB_SIZE_BITS;
  localparam logic [LIMB_INDEX_BITS-1:0] LAST_LIMB = LIMB_INDEX_BITS'(NUM_LIMBS - 1);

  disp_state_e                state_q, state_d;
  logic [JOB_BITS-1:0]        re_buf_q, re_buf_d;
  logic [JOB_BITS-1:0]        im_buf_q, im_buf_d;
  logic [TAG_BITS-1:0]        tag_buf_q, tag_buf_d;
  logic [CYCLE_BITS-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic                       job_ready_q, job_ready_d;
  logic                       wr_en_q, wr_en_d;
  logic [LIMB_INDEX_BITS-1:0] wr_limb_q, wr_limb_d;
  logic [LIMB_SIZE_BITS-1:0]  wr_data_re_q, wr_data_re_d;
  logic [LIMB_SIZE_BITS-1:0]  wr_data_im_q, wr_data_im_d;
  logic                       start_q, start_d;
  logic                       res_valid_q, res_valid_d;
  logic                       res_diverged_q, res_diverged_d;
  logic [CYCLE_BITS-1:0]      res_cycles_q, res_cycles_d;
  logic [TAG_BITS-1:0]        res_tag_q, res_tag_d;

  always_comb begin
    state_d        = state_q;
    re_buf_d       = re_buf_q;
    im_buf_d       = im_buf_q;
    tag_buf_d      = tag_buf_q;
    cyc_cnt_d      = cyc_cnt_q;
    job_ready_d    = 1'b0;
    wr_en_d        = 1'b0;
    wr_limb_d      = '0;
    wr_data_re_d   = '0;
    wr_data_im_d   = '0;
    start_d        = 1'b0;
    res_valid_d    = res_valid_q;
    res_diverged_d = res_diverged_q;
    res_cycles_d   = res_cycles_q;
    res_tag_d      = res_tag_q;

    case (state_q)
      ST_IDLE: begin
        job_ready_d = 1'b1;
        if (job_valid && job_ready_q) begin
          // Limb 0 goes out straight from the inputs; the buffers keep the
          // remaining limbs pre-shifted so the next one is always in the low slot.
          job_ready_d  = 1'b0;
          re_buf_d     = job_re >> LIMB_SIZE_BITS;
          im_buf_d     = job_im >> LIMB_SIZE_BITS;
          tag_buf_d    = job_tag;
          wr_en_d      = 1'b1;
          wr_data_re_d = job_re[LIMB_SIZE_BITS-1:0];
          wr_data_im_d = job_im[LIMB_SIZE_BITS-1:0];
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wr_limb_q == LAST_LIMB) begin
          start_d = 1'b1;
          state_d = ST_START;
        end else begin
          wr_en_d      = 1'b1;
          wr_limb_d    = wr_limb_q + LIMB_INDEX_BITS'(1);
          wr_data_re_d = re_buf_q[LIMB_SIZE_BITS-1:0];
          wr_data_im_d = im_buf_q[LIMB_SIZE_BITS-1:0];
          re_buf_d     = re_buf_q >> LIMB_SIZE_BITS;
          im_buf_d     = im_buf_q >> LIMB_SIZE_BITS;
        end
      end
      ST_START: begin
        cyc_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (solver_done) begin
          res_diverged_d = solver_output;
          res_cycles_d   = cyc_cnt_q;
          res_tag_d      = tag_buf_q;
          res_valid_d    = 1'b1;
          state_d        = ST_RESULT;
        end else if (cyc_cnt_q != '1) begin
          cyc_cnt_d = cyc_cnt_q + CYCLE_BITS'(1);
        end
      end
      ST_RESULT: begin
        // Raising job_ready here lets a new job be accepted on the very next cycle.
        if (res_ready) begin
          res_valid_d = 1'b0;
          job_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      re_buf_q       <= '0;
      im_buf_q       <= '0;
      tag_buf_q      <= '0;
      cyc_cnt_q      <= '0;
      job_ready_q    <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_limb_q      <= '0;
      wr_data_re_q   <= '0;
      wr_data_im_q   <= '0;
      start_q        <= 1'b0;
      res_valid_q    <= 1'b0;
      res_diverged_q <= 1'b0;
      res_cycles_q   <= '0;
      res_tag_q      <= '0;
    end else begin
      state_q        <= state_d;
      re_buf_q       <= re_buf_d;
      im_buf_q       <= im_buf_d;
      tag_buf_q      <= tag_buf_d;
      cyc_cnt_q      <= cyc_cnt_d;
      job_ready_q    <= job_ready_d;
      wr_en_q        <= wr_en_d;
      wr_limb_q      <= wr_limb_d;
      wr_data_re_q   <= wr_data_re_d;
      wr_data_im_q   <= wr_data_im_d;
      start_q        <= start_d;
      res_valid_q    <= res_valid_d;
      res_diverged_q <= res_diverged_d;
      res_cycles_q   <= res_cycles_d;
      res_tag_q      <= res_tag_d;
    end
  end

  assign job_ready    = job_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_limb      = wr_limb_q;
  assign wr_data_re   = wr_data_re_q;
  assign wr_data_im   = wr_data_im_q;
  assign start        = start_q;
  assign res_valid    = res_valid_q;
  assign res_diverged = res_diverged_q;
  assign res_cycles   = res_cycles_q;
  assign res_tag      = res_tag_q;

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch: a 4-limb/16-bit-counter instance and a
// 1-limb/4-bit-counter instance for the single-limb and saturation corners.
module tb_solver_dispatch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        job_valid, job_ready;
  logic [31:0] job_re, job_im;
  logic [15:0] job_tag;
  logic        wr_en;
  logic [5:0]  wr_limb;
  logic [7:0]  wr_data_re, wr_data_im;
  logic        start, solver_done, solver_output;
  logic        res_valid, res_ready, res_diverged;
  logic [15:0] res_cycles, res_tag;

  logic        job_valid2, job_ready2;
  logic [7:0]  job_re2, job_im2;
  logic [15:0] job_tag2;
  logic        wr_en2;
  logic [5:0]  wr_limb2;
  logic [7:0]  wr_data_re2, wr_data_im2;
  logic        start2, solver_done2, solver_output2;
  logic        res_valid2, res_ready2, res_diverged2;
  logic [3:0]  res_cycles2;
  logic [15:0] res_tag2;

  solver_dispatch dut (
    .clock(clk), .reset(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_re(job_re), .job_im(job_im), .job_tag(job_tag),
    .wr_en(wr_en), .wr_limb(wr_limb), .wr_data_re(wr_data_re), .wr_data_im(wr_data_im),
    .start(start), .solver_done(solver_done), .solver_output(solver_output),
    .res_valid(res_valid), .res_ready(res_ready), .res_diverged(res_diverged),
    .res_cycles(res_cycles), .res_tag(res_tag)
  );

  solver_dispatch #(.NUM_LIMBS(1), .CYCLE_BITS(4)) dut2 (
    .clock(clk), .reset(rst_n),
    .job_valid(job_valid2), .job_ready(job_ready2),
    .job_re(job_re2), .job_im(job_im2), .job_tag(job_tag2),
    .wr_en(wr_en2), .wr_limb(wr_limb2), .wr_data_re(wr_data_re2), .wr_data_im(wr_data_im2),
    .start(start2), .solver_done(solver_done2), .solver_output(solver_output2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_diverged(res_diverged2),
    .res_cycles(res_cycles2), .res_tag(res_tag2)
  );

  typedef struct {
    logic [31:0]      re;
    logic [31:0]      im;
    logic [15:0]      tag;
    int               wait_n;
    logic             outv;
    logic             spur;
    logic [0:3][7:0]  exp_re;
    logic [0:3][7:0]  exp_im;
    logic [15:0]      exp_cycles;
  } vec_t;

  vec_t vecs[3];
  int checks = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Accepts v, checks the limb stream and start pulse, then plays the solver
  // by raising done on WAIT cycle wait_n+1. Returns just after res_valid rises.
  task automatic run_job(input vec_t v);
    chk("job_ready_idle", 32'(job_ready), 32'd1);
    job_valid = 1'b1; job_re = v.re; job_im = v.im; job_tag = v.tag;
    step();
    job_valid = 1'b0; job_re = ~v.re; job_im = ~v.im; job_tag = ~v.tag;
    solver_done = v.spur; solver_output = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("load_wr_en", 32'(wr_en), 32'd1);
      chk("load_wr_limb", 32'(wr_limb), 32'(k));
      chk("load_data_re", 32'(wr_data_re), 32'(v.exp_re[k]));
      chk("load_data_im", 32'(wr_data_im), 32'(v.exp_im[k]));
      chk("load_job_ready", 32'(job_ready), 32'd0);
      step();
    end
    chk("start_pulse", 32'(start), 32'd1);
    chk("start_wr_en", 32'(wr_en), 32'd0);
    step();
    solver_done = 1'b0; solver_output = 1'b0;
    chk("start_once", 32'(start), 32'd0);
    chk("wait_res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < v.wait_n; i++) step();
    solver_done = 1'b1; solver_output = v.outv;
    step();
    solver_done = 1'b0; solver_output = 1'b0;
  endtask

  task automatic check_result(input vec_t v);
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_diverged", 32'(res_diverged), 32'(v.outv));
    chk("res_cycles", 32'(res_cycles), 32'(v.exp_cycles));
    chk("res_tag", 32'(res_tag), 32'(v.tag));
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("job_ready_after", 32'(job_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{re: 32'h0000_0001, im: 32'h0000_0001, tag: 16'hBEEF, wait_n: 10, outv: 1'b1, spur: 1'b0,
                exp_re: {8'h01, 8'h00, 8'h00, 8'h00}, exp_im: {8'h01, 8'h00, 8'h00, 8'h00}, exp_cycles: 16'd10};
    vecs[1] = '{re: 32'hA1B2_C3D4, im: 32'h1122_3344, tag: 16'h1234, wait_n: 0, outv: 1'b0, spur: 1'b0,
                exp_re: {8'hD4, 8'hC3, 8'hB2, 8'hA1}, exp_im: {8'h44, 8'h33, 8'h22, 8'h11}, exp_cycles: 16'd0};
    vecs[2] = '{re: 32'hFF00_FF00, im: 32'h0F0E_0D0C, tag: 16'h0001, wait_n: 3, outv: 1'b1, spur: 1'b1,
                exp_re: {8'h00, 8'hFF, 8'h00, 8'hFF}, exp_im: {8'h0C, 8'h0D, 8'h0E, 8'h0F}, exp_cycles: 16'd3};

    job_valid = 0; job_re = 0; job_im = 0; job_tag = 0;
    solver_done = 0; solver_output = 0; res_ready = 0;
    job_valid2 = 0; job_re2 = 0; job_im2 = 0; job_tag2 = 0;
    solver_done2 = 0; solver_output2 = 0; res_ready2 = 0;

    // Power-on reset, asserted and released between clock edges.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_job_ready", 32'(job_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_release_ready_low", 32'(job_ready), 32'd0);
    step();
    chk("rst_release_ready_high", 32'(job_ready), 32'd1);

    for (int i = 0; i < 3; i++) begin
      run_job(vecs[i]);
      check_result(vecs[i]);
      accept_result();
    end

    // Result backpressure with a competing job offered.
    run_job(vecs[2]);
    job_valid = 1'b1; job_re = 32'hDEAD_BEEF; job_im = 32'h0; job_tag = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      step();
      check_result(vecs[2]);
      chk("bp_job_ready", 32'(job_ready), 32'd0);
      chk("bp_wr_en", 32'(wr_en), 32'd0);
    end
    job_valid = 1'b0;
    accept_result();
    step();
    chk("bp_no_accept", 32'(wr_en), 32'd0);

    // Reset while waiting on the solver, then a clean job from limb 0.
    job_valid = 1'b1; job_re = vecs[1].re; job_im = vecs[1].im; job_tag = vecs[1].tag;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_job_ready", 32'(job_ready), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_start", 32'(start), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_tag", 32'(res_tag), 32'd0);
    chk("midrst_res_cycles", 32'(res_cycles), 32'd0);
    #2 rst_n = 1'b1;
    step();
    run_job(vecs[0]);
    check_result(vecs[0]);
    accept_result();

    // Single-limb instance: one-cycle load and 4-bit counter saturation.
    chk("s_job_ready", 32'(job_ready2), 32'd1);
    job_valid2 = 1'b1; job_re2 = 8'h5A; job_im2 = 8'hA5; job_tag2 = 16'h0042;
    step();
    job_valid2 = 1'b0;
    chk("s_wr_en", 32'(wr_en2), 32'd1);
    chk("s_wr_limb", 32'(wr_limb2), 32'd0);
    chk("s_data_re", 32'(wr_data_re2), 32'h5A);
    chk("s_data_im", 32'(wr_data_im2), 32'hA5);
    step();
    chk("s_start", 32'(start2), 32'd1);
    chk("s_start_wr_en", 32'(wr_en2), 32'd0);
    step();
    for (int i = 0; i < 20; i++) step();
    solver_done2 = 1'b1;
    step();
    solver_done2 = 1'b0;
    chk("s_res_valid", 32'(res_valid2), 32'd1);
    chk("s_res_cycles_sat", 32'(res_cycles2), 32'hF);
    chk("s_res_tag", 32'(res_tag2), 32'h0042);
    chk("s_res_diverged", 32'(res_diverged2), 32'd0);
    res_ready2 = 1'b1;
    step();
    res_ready2 = 1'b0;
    chk("s_res_valid_drop", 32'(res_valid2), 32'd0);
    chk("s_job_ready_after", 32'(job_ready2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/solver_dispatch.md
Name: solver_dispatch

Overview:
- Upstream feeder for `solver`. Accepts one pixel job (full-width c_re/c_im plus a tag) over a valid/ready handshake.
- Streams the job limb-serially into the solver's write port, pulses start, waits for done, then returns the divergence result with cycle count and tag.
- Sits between the tile/pixel scheduler and one `solver` instance.

Parameters:
- LIMB_INDEX_BITS, 6, width of wr_limb; must be able to index NUM_LIMBS-1.
- LIMB_SIZE_BITS, 8, bits per limb.
- NUM_LIMBS, 4, limbs per coordinate; 1..2**LIMB_INDEX_BITS.
- TAG_BITS, 16, opaque job tag width.
- CYCLE_BITS, 16, width of the saturating solve-cycle counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  dispatcher can accept a job.
- job_re  in  NUM_LIMBS*LIMB_SIZE_BITS  c real part, limb 0 = bits [LIMB_SIZE_BITS-1:0].
- job_im  in  NUM_LIMBS*LIMB_SIZE_BITS  c imaginary part, same layout.
- job_tag  in  TAG_BITS  returned unchanged with the result.
- wr_en  out  1  to solver.wr_en.
- wr_limb  out  LIMB_INDEX_BITS  to solver.wr_limb.
- wr_data_re  out  LIMB_SIZE_BITS  to solver.wr_data_re.
- wr_data_im  out  LIMB_SIZE_BITS  to solver.wr_data_im.
- start  out  1  to solver.start.
- solver_done  in  1  from solver.done.
- solver_output  in  1  from solver.output (1 = diverged).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_diverged  out  1  captured solver_output.
- res_cycles  out  CYCLE_BITS  WAIT cycles before done was seen.
- res_tag  out  TAG_BITS  tag of the completed job.

Behaviour:
- All outputs are registered.
- Reset (reset==0, async): state IDLE. job_ready=0 while reset is asserted and becomes 1 on the first clock after deassertion. wr_en=0, wr_limb=0, wr_data_*=0, start=0, res_valid=0, res_diverged=0, res_cycles=0, res_tag=0. Internal job buffer and counters are cleared.
- FSM states: IDLE, LOAD, START, WAIT, RESULT.
- IDLE:
  - job_ready=1.
  - On job_valid&&job_ready: capture job_re/job_im/job_tag, set job_ready=0, go to LOAD.
- LOAD:
  - Lasts NUM_LIMBS cycles; the first wr_en cycle is the cycle after acceptance.
  - In cycle k (0..NUM_LIMBS-1): wr_en=1, wr_limb=k, wr_data_re/im = limb k of the captured job.
  - Limb order is ascending, LSB first.
  - After limb NUM_LIMBS-1, go to START.
- START:
  - One cycle with start=1, wr_en=0.
  - Cycle counter is cleared.
  - Go to WAIT.
- WAIT:
  - start=0.
  - solver_done==0: counter increments, saturating at 2**CYCLE_BITS-1.
  - solver_done==1: latch res_diverged=solver_output, res_cycles=counter, res_tag=captured tag; set res_valid=1 the next cycle; go to RESULT.
  - Done seen on the first WAIT cycle gives res_cycles=0.
- RESULT:
  - res_valid=1, and all res_* are held stable until res_valid&&res_ready.
  - On that handshake: res_valid=0, go to IDLE; job_ready=1 on the following cycle.
- solver_done is ignored in IDLE, LOAD, START and RESULT.
- job_ready is 0 in every state except IDLE. There is no job overlap (single buffer).
- Job fields are sampled only on the accept edge. Later changes to job_* do not affect the job in flight.
- NUM_LIMBS=1: LOAD lasts one cycle.
- Reset mid-operation (any state): immediate return to reset values. Any partial limb load is abandoned. The solver is reset by its own reset and no recovery sequence is issued.

Decomposition:
- Shared package (solver_pkg): FSM state encoding, limb-slicing helper constant for LIMB_SIZE_BITS, default widths (LIMB_INDEX_BITS, LIMB_SIZE_BITS) shared with `solver`.
- No sub-module required. The saturating counter stays inline; a generic `sat_counter` may be factored out only if reused elsewhere.

Test Plan:
- Reset: assert reset=0 mid-clock -> all outputs 0 immediately; job_ready=1 one cycle after deassertion.
- Load order: NUM_LIMBS=4, job_re=32'h0000_0001, job_im=32'h0000_0001, tag=16'hBEEF -> wr_en high 4 cycles, wr_limb 0,1,2,3, wr_data_re/im 01,00,00,00; start=1 exactly one cycle after limb 3; job_ready=0 throughout.
- Result capture: solver model asserts done with output=1 on the 11th WAIT cycle -> res_valid=1, res_diverged=1, res_cycles=10, res_tag=16'hBEEF.
- Backpressure: res_ready=0 for 5 cycles -> res_* stable, job_ready=0, job_valid ignored; res_ready=1 -> res_valid drops, job_ready=1 next cycle.
- Saturation / spurious done: CYCLE_BITS=4, done after 20 WAIT cycles -> res_cycles=15; done pulsed during LOAD -> ignored, full load and start still occur.
- Reset in WAIT: drop reset during WAIT -> outputs 0; after release, a new job loads correctly from limb 0.
